// File: rtl/mips_prog_loader.sv
// Program loader and run controller for the 5-stage MIPS pipeline: streams a program into
// instruction memory, releases the core, then waits for PC-past-end or a cycle limit. Option: PROG_CHECKSUM_EN.
module mips_prog_loader #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int CNT_W      = 16,
    parameter int MAX_CYCLES = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   prog_len,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_reset,
    input  logic [31:0]       core_pc,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycles
`ifdef PROG_CHECKSUM_EN
    ,
    input  logic [DATA_W-1:0] exp_sum,
    output logic              sum_err
`endif
);

    localparam int              DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L  = (ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(MAX_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RELEASE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [ADDR_W:0] len_q;
    logic [ADDR_W:0] wcount;
    logic [ADDR_W:0] len_next;
    logic [31:0]     pc_limit;
    logic            hs;
    logic            last_word;
    logic            pc_past;

    always_comb begin
        len_next  = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
        hs        = s_valid && s_ready;
        last_word = ((wcount + (ADDR_W + 1)'(1)) == len_q);
        pc_limit  = 32'({len_q, 2'b00});
        pc_past   = (core_pc >= pc_limit);
    end

`ifdef PROG_CHECKSUM_EN
    logic [DATA_W-1:0] sum_q;
    logic [DATA_W-1:0] sum_next;

    always_comb begin
        sum_next = sum_q + s_data;
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            len_q      <= '0;
            wcount     <= '0;
            s_ready    <= 1'b0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            core_reset <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            cycles     <= '0;
`ifdef PROG_CHECKSUM_EN
            sum_q      <= '0;
            sum_err    <= 1'b0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        len_q   <= len_next;
                        wcount  <= '0;
                        done    <= 1'b0;
                        timeout <= 1'b0;
                        cycles  <= '0;
`ifdef PROG_CHECKSUM_EN
                        sum_q   <= '0;
                        sum_err <= 1'b0;
`endif
                        if (len_next == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= LOAD;
                            s_ready <= 1'b1;
                            busy    <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (hs) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= wcount[ADDR_W-1:0];
                        imem_wdata <= s_data;
                        wcount     <= wcount + (ADDR_W + 1)'(1);
`ifdef PROG_CHECKSUM_EN
                        sum_q      <= sum_next;
`endif
                        if (last_word) begin
                            s_ready <= 1'b0;
`ifdef PROG_CHECKSUM_EN
                            // Sum includes the word being accepted on this edge
                            if (sum_next != exp_sum) begin
                                sum_err <= 1'b1;
                                busy    <= 1'b0;
                                state   <= DONE;
                            end else begin
                                state <= RELEASE;
                            end
`else
                            state <= RELEASE;
`endif
                        end
                    end
                end
                RELEASE: begin
                    cycles     <= '0;
                    core_reset <= 1'b0;
                    state      <= RUN;
                end
                RUN: begin
                    // PC check has priority so a simultaneous limit hit reports done
                    if (pc_past) begin
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        core_reset <= 1'b1;
                        state      <= DONE;
                    end else if (cycles == LAST_CYC) begin
                        timeout    <= 1'b1;
                        busy       <= 1'b0;
                        core_reset <= 1'b1;
                        state      <= DONE;
                    end else begin
                        cycles <= cycles + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_prog_loader.sv
// Scoreboard bench for mips_prog_loader: expected writes queued on handshake, popped on imem_we.
module tb_mips_prog_loader;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 5;
    localparam int CNT_W   = 16;
    localparam int MAX_CYC = 20;

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W:0]   prog_len;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic              core_reset;
    logic [31:0]       core_pc;
    logic              busy;
    logic              done;
    logic              timeout;
    logic [CNT_W-1:0]  cycles;
`ifdef PROG_CHECKSUM_EN
    logic [DATA_W-1:0] exp_sum;
    logic              sum_err;
`endif

    mips_prog_loader #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .CNT_W     (CNT_W),
        .MAX_CYCLES(MAX_CYC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .prog_len  (prog_len),
        .s_valid   (s_valid),
        .s_data    (s_data),
        .s_ready   (s_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_reset(core_reset),
        .core_pc   (core_pc),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
`ifdef PROG_CHECKSUM_EN
        .exp_sum   (exp_sum),
        .sum_err   (sum_err),
`endif
        .cycles    (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Stand-in core: PC advances one word per cycle once released
    logic [31:0] pc;
    bit          pc_hold;
    always_ff @(posedge clk) pc <= (core_reset || pc_hold) ? 32'd0 : pc + 32'd4;
    assign core_pc = pc;

    logic [DATA_W-1:0] words [64];
    bit                bp_pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    logic [ADDR_W-1:0] q_addr [$];
    logic [DATA_W-1:0] q_data [$];

    always @(negedge clk) begin
        if (reset && imem_we) begin
            if (q_addr.size() == 0) begin
                check("we_unexpected", 64'(imem_addr), 64'hFFFF);
            end else begin
                check("waddr", 64'(imem_addr), 64'(q_addr.pop_front()));
                check("wdata", 64'(imem_wdata), 64'(q_data.pop_front()));
            end
        end
    end

    task automatic do_start(input int plen);
        start    = 1'b1;
        prog_len = (ADDR_W + 1)'(plen);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic stream(input int n, input bit bp);
        int sent  = 0;
        int k     = 0;
        int guard = 0;
        bit v;
        while (sent < n) begin
            if (guard > 500) begin
                check("stream_bound", 64'(sent), 64'(n));
                break;
            end
            guard++;
            v       = bp ? bp_pat[k % 7] : 1'b1;
            start   = bp && (k == 1);
            if (start) prog_len = '0;
            k++;
            s_valid = v;
            s_data  = words[sent];
            if (v && s_ready) begin
                q_addr.push_back(ADDR_W'(sent));
                q_data.push_back(words[sent]);
                sent++;
            end
            @(negedge clk);
        end
        s_valid = 1'b0;
        start   = 1'b0;
    endtask

    task automatic wait_end();
        int g = 0;
        while (busy && g < 300) begin
            @(negedge clk);
            g++;
        end
        check("end_bound", 64'(busy), 64'd0);
    endtask

    task automatic run_case(input string name, input int plen, input bit bp, input bit hold,
                            input int exp_cyc, input bit exp_done, input bit exp_to);
        int eff;
        eff = (plen > 32) ? 32 : plen;
`ifdef PROG_CHECKSUM_EN
        exp_sum = '0;
        for (int i = 0; i < eff; i++) exp_sum += words[i];
`endif
        pc_hold = hold;
        do_start(plen);
        if (eff == 0) begin
            check({name, "_done"}, 64'(done), 64'd1);
            check({name, "_busy"}, 64'(busy), 64'd0);
            check({name, "_to"}, 64'(timeout), 64'd0);
            check({name, "_cyc"}, 64'(cycles), 64'd0);
            check({name, "_core"}, 64'(core_reset), 64'd1);
            @(negedge clk);
            check({name, "_sb"}, 64'(q_addr.size()), 64'd0);
            return;
        end
        check({name, "_busy"}, 64'(busy), 64'd1);
        check({name, "_clr"}, 64'({done, timeout}), 64'd0);
        check({name, "_cyc0"}, 64'(cycles), 64'd0);
        stream(eff, bp);
        check({name, "_rdy_drop"}, 64'(s_ready), 64'd0);
        check({name, "_rel_hold"}, 64'(core_reset), 64'd1);
        @(negedge clk);
        check({name, "_released"}, 64'(core_reset), 64'd0);
        wait_end();
        check({name, "_done"}, 64'(done), 64'(exp_done));
        check({name, "_to"}, 64'(timeout), 64'(exp_to));
        check({name, "_cyc"}, 64'(cycles), 64'(exp_cyc));
        check({name, "_core"}, 64'(core_reset), 64'd1);
`ifdef PROG_CHECKSUM_EN
        check({name, "_sumerr"}, 64'(sum_err), 64'd0);
`endif
        check({name, "_sb"}, 64'(q_addr.size()), 64'd0);
        pc_hold = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset    = 1'b0;
        start    = 1'b0;
        prog_len = '0;
        s_valid  = 1'b0;
        s_data   = '0;
        pc_hold  = 1'b0;
`ifdef PROG_CHECKSUM_EN
        exp_sum  = '0;
`endif
        for (int i = 0; i < 64; i++) words[i] = $urandom;
        words[0]  = 32'h8C010000; words[1]  = 32'h8C020004; words[2]  = 32'h00221820;
        words[3]  = 32'h8C040008; words[4]  = 32'h00642820; words[5]  = 32'h00A13020;
        words[6]  = 32'h8C07000C; words[7]  = 32'h00E64020; words[8]  = 32'h01024820;
        words[9]  = 32'h8C0A0010; words[10] = 32'h012A5820;

        repeat (3) @(negedge clk);
        check("rst_core", 64'(core_reset), 64'd1);
        check("rst_outs", 64'({s_ready, busy, done, timeout, imem_we}), 64'd0);
        check("rst_cyc", 64'(cycles), 64'd0);
        reset = 1'b1;
        @(negedge clk);

        do_start(8);
        stream(3, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_core", 64'(core_reset), 64'd1);
        check("abort_rdy", 64'(s_ready), 64'd0);
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_we", 64'(imem_we), 64'd0);
        check("abort_sb", 64'(q_addr.size()), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        run_case("reload", 8, 1'b0, 1'b0, 8, 1'b1, 1'b0);
        run_case("demo", 11, 1'b0, 1'b0, 11, 1'b1, 1'b0);
        run_case("bp", 4, 1'b1, 1'b0, 4, 1'b1, 1'b0);
        run_case("tmo", 2, 1'b0, 1'b1, 19, 1'b0, 1'b1);
        run_case("len0", 0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        run_case("both", 19, 1'b0, 1'b0, 19, 1'b1, 1'b0);
        run_case("clamp", 40, 1'b0, 1'b0, 19, 1'b0, 1'b1);

`ifdef PROG_CHECKSUM_EN
        words[0] = 32'd1; words[1] = 32'd2; words[2] = 32'd3;
        run_case("sum_ok", 3, 1'b0, 1'b0, 3, 1'b1, 1'b0);
        exp_sum = 32'd7;
        do_start(3);
        stream(3, 1'b0);
        check("sum_err", 64'(sum_err), 64'd1);
        check("sum_core", 64'(core_reset), 64'd1);
        check("sum_flags", 64'({busy, done, timeout}), 64'd0);
        @(negedge clk);
        check("sum_core2", 64'(core_reset), 64'd1);
        check("sum_sb", 64'(q_addr.size()), 64'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
